// File: rtl/btn_toggle_pkg.sv
// Shared types and defaults for the push-button toggle pulse generator.
package btn_toggle_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_REPEAT_CYCLES   = 16;
  localparam int unsigned DEF_CNT_W           = 8;

  // Bits needed to hold 0..n, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_toggle_gen_sync2.sv
// 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_toggle_gen.sv
// Debounces a raw push-button into one-cycle toggle pulses with optional
// hold-to-repeat and a wrapping count of accepted presses.
module btn_toggle_gen
  import btn_toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  output logic             t,
  output logic             pressed,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned CW        = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RW        = cnt_width(REPEAT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic          REPEAT_EN = (REPEAT_CYCLES != 0);

  logic          btn_s;
  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          t_nxt;
  logic          count_en;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (btn_s)
  );

  // Next-state, counter and pulse decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    t_nxt     = 1'b0;
    count_en  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = ARM_PRESS;
          cnt_nxt   = '0;
        end
      end
      ARM_PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          t_nxt     = 1'b1;
          count_en  = 1'b1;
          rcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = ARM_RELEASE;
          cnt_nxt   = '0;
        end else if (REPEAT_EN) begin
          // Gating on t keeps pulses separated even with a 1-cycle period.
          if (rcnt == RCNT_LAST) begin
            rcnt_nxt = '0;
            t_nxt    = !t;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
      end
      ARM_RELEASE: begin
        if (btn_s) begin
          state_nxt = HELD;
          rcnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        rcnt_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      t           <= 1'b0;
      pressed     <= 1'b0;
      press_count <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rcnt    <= rcnt_nxt;
      t       <= t_nxt;
      pressed <= (state_nxt == HELD) || (state_nxt == ARM_RELEASE);
      if (count_en) begin
        press_count <= press_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_toggle_gen.sv
// Scoreboard bench: two instances (repeat 16 and repeat disabled) share one button.
module tb_btn_toggle_gen;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       t16, pr16, t0, pr0;
  logic [7:0] pc16, pc0;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         seen16 = 0;
  int         seen0 = 0;
  logic [7:0] exp_cnt = 8'd0;
  exp_t       q16[$];
  exp_t       q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .t(t16), .pressed(pr16), .press_count(pc16)
  );

  btn_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .btn(btn), .t(t0), .pressed(pr0), .press_count(pc0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitors: every t pulse must match the head of its expected queue.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (t16 === 1'b1) begin
      seen16++;
      if (q16.size() == 0) begin
        chk("t16_unexpected", 1, 0);
      end else begin
        e = q16.pop_front();
        chk("t16_cyc", cyc, e.cyc);
        chk("t16_cnt", int'(pc16), int'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (t0 === 1'b1) begin
      seen0++;
      if (q0.size() == 0) begin
        chk("t0_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("t0_cyc", cyc, e.cyc);
        chk("t0_cnt", int'(pc0), int'(e.cnt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int n);
    do step(); while (cyc < n);
  endtask

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_pressed(input string nm, input int exp);
    chk({nm, "_pr16"}, int'(pr16), exp);
    chk({nm, "_pr0"}, int'(pr0), exp);
  endtask

  task automatic push_first(input int b);
    exp_cnt = exp_cnt + 8'd1;
    q16.push_back('{b + 7, exp_cnt});
    q0.push_back('{b + 7, exp_cnt});
  endtask

  // Called just after a rising edge; pressed falls 6 edges after the first 0 sample.
  task automatic release_btn();
    int r;
    r = cyc;
    btn = 1'b0;
    wait_neg(r + 6);
    chk_pressed("rel_still_high", 1);
    wait_neg(r + 7);
    chk_pressed("rel_fall", 0);
    wait_pos(r + 9);
  endtask

  // Hold btn for h sampling edges (h >= 8), then release.
  task automatic press(input int h);
    int b;
    b = cyc;
    btn = 1'b1;
    push_first(b);
    for (int k = 1; 4 + 16 * k <= h - 1; k++) q16.push_back('{b + 7 + 16 * k, exp_cnt});
    wait_neg(b + 6);
    chk_pressed("press_not_yet", 0);
    wait_neg(b + 7);
    chk_pressed("press_rise", 1);
    wait_pos(b + h);
    release_btn();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic bseq[8];
    int   b;
    int   r;
    int   s16;
    int   s0;

    // Power-on reset
    #2 rst = 1'b0;
    #1;
    chk("por_t16", int'(t16), 0);
    chk("por_pc16", int'(pc16), 0);
    chk_pressed("por", 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Clean press: single pulse
    press(12);
    chk("clean_pc16", int'(pc16), 1);
    chk("clean_pc0", int'(pc0), 1);

    // Bounce never qualifies
    bseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      btn = bseq[i];
      step();
    end
    btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_pressed("bounce", 0);
    end
    step();
    chk("bounce_pc16", int'(pc16), int'(exp_cnt));

    // Long hold: repeats only on the R=16 instance
    press(40);
    chk("hold_pc16", int'(pc16), 2);
    chk("hold_pc0", int'(pc0), 2);

    // Short release glitch while held
    b = cyc;
    btn = 1'b1;
    push_first(b);
    wait_pos(b + 10);
    btn = 1'b0;
    wait_pos(b + 12);
    btn = 1'b1;
    for (int n = b + 13; n <= b + 19; n++) begin
      wait_neg(n);
      chk_pressed("glitch_hold", 1);
    end
    wait_pos(b + 20);
    release_btn();
    chk("glitch_pc16", int'(pc16), 3);

    // Asynchronous reset mid-press with btn held high
    b = cyc;
    btn = 1'b1;
    push_first(b);
    wait_neg(b + 9);
    #2 rst = 1'b0;
    #1;
    chk("rst_t16", int'(t16), 0);
    chk("rst_t0", int'(t0), 0);
    chk("rst_pc16", int'(pc16), 0);
    chk("rst_pc0", int'(pc0), 0);
    chk_pressed("rst", 0);
    exp_cnt = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_t16", int'(t16), 0);
    chk_pressed("rst_held", 0);
    @(negedge clk);
    rst = 1'b1;
    r = cyc;
    push_first(r);
    wait_neg(r + 6);
    chk_pressed("rst_restart_not_yet", 0);
    wait_neg(r + 7);
    chk_pressed("rst_restart_rise", 1);
    wait_pos(r + 12);
    release_btn();

    // 256 presses: count wraps, one pulse each
    s16 = seen16;
    s0 = seen0;
    for (int i = 0; i < 256; i++) press(8);
    chk("wrap_pulses16", seen16 - s16, 256);
    chk("wrap_pulses0", seen0 - s0, 256);
    chk("wrap_pc16", int'(pc16), 1);
    chk("wrap_pc0", int'(pc0), 1);

    wait_pos(cyc + 30);
    chk("q16_drained", q16.size(), 0);
    chk("q0_drained", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
